// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg                                                              |
// | Shared encodings for the cache-to-memory line arbiter.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER_I = 2'd1,
      XFER_D = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // Byte offset of a 32-bit word inside the address
   localparam int c_word_ofs = 2;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pick                                                             |
// | Combinational owner selection between I and D line requests.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   i_ireq,
   input  logic   i_dreq,
   input  logic   i_favour_d,
   output logic   o_valid,
   output owner_t o_owner
);

   always_comb begin
      o_valid = i_ireq | i_dreq;
      o_owner = OWN_D;
      // I takes the port when alone, or on a tie that currently favours I
      if (i_ireq && !(i_dreq && i_favour_d)) begin
         o_owner = OWN_I;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter                                                              |
// | Shares one memory port between I-cache refill and D-cache refill/        |
// | writeback, one whole line per grant. MEM_ARB_RR_EN selects round-robin   |
// | tie-breaking; otherwise D always wins a tie.                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
)(
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          I_REQ,
   input  logic [ADDR_W-1:0]             I_ADDR,
   output logic                          I_RVALID,
   output logic [31:0]                   I_RDATA,
   output logic                          I_DONE,
   input  logic                          D_REQ,
   input  logic                          D_WE,
   input  logic [ADDR_W-1:0]             D_ADDR,
   input  logic [31:0]                   D_WDATA,
   output logic                          D_WREADY,
   output logic                          D_RVALID,
   output logic [31:0]                   D_RDATA,
   output logic                          D_DONE,
   output logic [$clog2(LINE_WORDS)-1:0] BEAT,
   output logic                          M_CS,
   output logic                          M_WE,
   output logic [ADDR_W-1:0]             M_ADDR,
   output logic [31:0]                   M_WDATA,
   input  logic [31:0]                   M_RDATA,
   input  logic                          M_RDY
);

   localparam int c_beat_w = $clog2(LINE_WORDS);
   localparam int c_base_w = ADDR_W - c_beat_w - c_word_ofs;
   localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(LINE_WORDS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   owner_t               r_owner;
   logic                 r_we;
   logic [c_base_w-1:0]  r_base;
   logic [c_beat_w-1:0]  r_beat;
   logic [c_beat_w-1:0]  w_beat_nxt;
   logic                 w_latch;
   logic                 w_grant_valid;
   owner_t               w_grant_owner;
   logic                 w_favour_d;
   logic                 w_in_xfer;
   logic                 w_unused_addr_lsbs;

   assign w_unused_addr_lsbs = ^{I_ADDR[c_beat_w+c_word_ofs-1:0],
                                 D_ADDR[c_beat_w+c_word_ofs-1:0]};

`ifdef MEM_ARB_RR_EN
   logic r_favour_d;

   // Whoever was granted last loses the next tie
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_favour_d <= 1'b1;
      end else if (w_latch) begin
         r_favour_d <= (w_grant_owner == OWN_I);
      end
   end

   assign w_favour_d = r_favour_d;
`else
   assign w_favour_d = 1'b1;
`endif

   mem_arb_pick u_pick (
      .i_ireq     (I_REQ),
      .i_dreq     (D_REQ),
      .i_favour_d (w_favour_d),
      .o_valid    (w_grant_valid),
      .o_owner    (w_grant_owner)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_beat  <= '0;
         r_owner <= OWN_D;
         r_we    <= 1'b0;
         r_base  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         if (w_latch) begin
            r_owner <= w_grant_owner;
            r_we    <= (w_grant_owner == OWN_D) && D_WE;
            r_base  <= (w_grant_owner == OWN_D) ? D_ADDR[ADDR_W-1 -: c_base_w]
                                                : I_ADDR[ADDR_W-1 -: c_base_w];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_valid) begin
               w_latch     = 1'b1;
               w_beat_nxt  = '0;
               w_state_nxt = (w_grant_owner == OWN_D) ? XFER_D : XFER_I;
            end
         end
         XFER_I, XFER_D: begin
            // BEAT holds on the final word and wraps only when DONE is left
            if (M_RDY) begin
               if (r_beat == c_last_beat) begin
                  w_state_nxt = DONE;
               end else begin
                  w_beat_nxt = r_beat + c_beat_w'(1);
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
         end
      endcase
   end

   assign w_in_xfer = (r_state == XFER_I) || (r_state == XFER_D);

   always_comb begin
      M_CS     = w_in_xfer;
      M_WE     = (r_state == XFER_D) && r_we;
      M_ADDR   = {r_base, r_beat, {c_word_ofs{1'b0}}};
      M_WDATA  = '0;
      BEAT     = r_beat;
      I_RVALID = 1'b0;
      I_RDATA  = '0;
      I_DONE   = 1'b0;
      D_RVALID = 1'b0;
      D_RDATA  = '0;
      D_WREADY = 1'b0;
      D_DONE   = 1'b0;
      if (M_WE) begin
         M_WDATA = D_WDATA;
      end
      if ((r_state == XFER_I) && M_RDY) begin
         I_RVALID = 1'b1;
         I_RDATA  = M_RDATA;
      end
      if ((r_state == XFER_D) && M_RDY) begin
         if (r_we) begin
            D_WREADY = 1'b1;
         end else begin
            D_RVALID = 1'b1;
            D_RDATA  = M_RDATA;
         end
      end
      if (r_state == DONE) begin
         I_DONE = (r_owner == OWN_I);
         D_DONE = (r_owner == OWN_D);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter                                                           |
// | Transaction-level model plus directed and randomized stimulus.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int          LW    = 4;
   localparam int          AW    = 32;
   localparam logic [31:0] LMASK = 32'hFFFF_FFF0;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0, M_RDY = 1'b0;
   logic [AW-1:0] I_ADDR = '0, D_ADDR = '0;
   logic [31:0]   D_WDATA = '0, M_RDATA = '0;
   logic          I_RVALID, I_DONE, D_WREADY, D_RVALID, D_DONE, M_CS, M_WE;
   logic [31:0]   I_RDATA, D_RDATA, M_WDATA;
   logic [AW-1:0] M_ADDR;
   logic [1:0]    BEAT;

   always #5 CLK = ~CLK;

   mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
      .CLK(CLK), .RST(RST),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA), .I_DONE(I_DONE),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_WREADY(D_WREADY),
      .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_DONE(D_DONE), .BEAT(BEAT),
      .M_CS(M_CS), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
      .M_RDATA(M_RDATA), .M_RDY(M_RDY)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: one line transaction in flight (owner, line base, word index),
   // a one-cycle completion marker, and the tie-break preference.
   bit          m_act = 0, m_done = 0, m_own = 0, m_we = 0, m_fav_d = 1;
   logic [31:0] m_base = '0;
   int          m_idx = 0;

   always @(posedge CLK) begin
      cyc++;
      if (RST) begin
         m_act = 0; m_done = 0; m_idx = 0; m_fav_d = 1;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_act) begin
         if (M_RDY) begin
            if (m_idx == LW - 1) begin
               m_act = 0; m_done = 1;
            end else begin
               m_idx++;
            end
         end
      end else if (I_REQ || D_REQ) begin
         m_own = D_REQ && !(I_REQ && !m_fav_d);
`ifdef MEM_ARB_RR_EN
         m_fav_d = !m_own;
`endif
         m_we   = m_own && D_WE;
         m_base = (m_own ? D_ADDR : I_ADDR) & LMASK;
         m_idx  = 0;
         m_act  = 1;
      end
   end

   // Event logs used by the directed literal checks
   int          n_idone = 0, n_ddone = 0, n_irv = 0, last_idone_cyc = 0;
   int          q_done_own[$];
   logic [31:0] q_irdata[$], q_iaddr[$], q_wdata[$], q_waddr[$];

   task automatic compare();
      logic        e_we;
      e_we = m_act && m_own && m_we;
      chk("M_CS", 32'(M_CS), 32'(m_act));
      chk("M_WE", 32'(M_WE), 32'(e_we));
      chk("M_WDATA", M_WDATA, e_we ? D_WDATA : 32'h0);
      chk("I_RVALID", 32'(I_RVALID), 32'(m_act && !m_own && M_RDY));
      chk("D_RVALID", 32'(D_RVALID), 32'(m_act && m_own && !m_we && M_RDY));
      chk("D_WREADY", 32'(D_WREADY), 32'(m_act && m_own && m_we && M_RDY));
      chk("I_DONE", 32'(I_DONE), 32'(m_done && !m_own));
      chk("D_DONE", 32'(D_DONE), 32'(m_done && m_own));
      if (m_act) begin
         chk("M_ADDR", M_ADDR, m_base + 32'(m_idx * 4));
         chk("BEAT", 32'(BEAT), 32'(m_idx));
         if (M_RDY && !m_own) chk("I_RDATA", I_RDATA, M_RDATA);
         if (M_RDY && m_own && !m_we) chk("D_RDATA", D_RDATA, M_RDATA);
      end
   endtask

   initial begin
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         compare();
         if (I_DONE) begin n_idone++; last_idone_cyc = cyc; q_done_own.push_back(0); end
         if (D_DONE) begin n_ddone++; q_done_own.push_back(1); end
         if (I_RVALID) begin n_irv++; q_irdata.push_back(I_RDATA); q_iaddr.push_back(M_ADDR); end
         if (D_WREADY) begin q_wdata.push_back(M_WDATA); q_waddr.push_back(M_ADDR); end
      end
   end

   // Memory and writeback-data responder
   bit rdata_pat = 0, wdata_pat = 0, idle_noise = 0, rand_lat = 0;
   int fix_lat = 0;

   initial begin
      int wcnt = 0;
      int lat  = 0;
      forever begin
         @(posedge CLK);
         #2;
         D_WDATA = wdata_pat ? 32'hD0 + 32'(BEAT) : $urandom();
         M_RDATA = rdata_pat ? 32'hA0 + 32'(BEAT) : $urandom();
         if (!M_CS) begin
            wcnt  = 0;
            M_RDY = idle_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            if (wcnt == 0) lat = rand_lat ? int'($urandom_range(0, 2)) : fix_lat;
            M_RDY = (wcnt >= lat);
            wcnt  = M_RDY ? 0 : wcnt + 1;
         end
      end
   end

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_done(input bit is_d, input int target, input int max);
      int k = 0;
      while (((is_d ? n_ddone : n_idone) < target) && k < max) begin
         next();
         k++;
      end
      chk(is_d ? "D_DONE wait" : "I_DONE wait", 32'((is_d ? n_ddone : n_idone) >= target), 32'h1);
   endtask

   initial begin
      int nd, n0, k, nexp, pi, pd;
      int exp_own[3];

      // Reset values
      next(); next();
      chk("rst M_CS", 32'(M_CS), 32'h0);
      chk("rst BEAT", 32'(BEAT), 32'h0);
      chk("rst M_ADDR", M_ADDR, 32'h0);
      chk("rst M_WDATA", M_WDATA, 32'h0);
      chk("rst DONE", 32'({I_DONE, D_DONE, I_RVALID, D_RVALID, D_WREADY}), 32'h0);
      RST = 1'b0;
      next();

      // I refill, zero-wait memory returning 0xA0..0xA3
      rdata_pat = 1; fix_lat = 0;
      q_irdata.delete(); q_iaddr.delete();
      n0 = cyc;
      I_ADDR = 32'h100; I_REQ = 1'b1;
      wait_done(0, 1, 20);
      I_REQ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("I word", (i < q_irdata.size()) ? q_irdata[i] : 32'hDEAD_BEEF, 32'hA0 + 32'(i));
         chk("I addr", (i < q_iaddr.size()) ? q_iaddr[i] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * i));
      end
      chk("I latency", 32'(last_idone_cyc - n0 + 1), 32'd6);

      // D writeback with slow memory
      rdata_pat = 0; wdata_pat = 1; fix_lat = 2;
      q_wdata.delete(); q_waddr.delete();
      n0 = n_irv; nd = n_idone;
      D_WE = 1'b1; D_ADDR = 32'h200; D_REQ = 1'b1;
      wait_done(1, 1, 60);
      D_REQ = 1'b0; D_WE = 1'b0;
      chk("WREADY count", 32'(q_wdata.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("W data", (i < q_wdata.size()) ? q_wdata[i] : 32'hDEAD_BEEF, 32'hD0 + 32'(i));
         chk("W addr", (i < q_waddr.size()) ? q_waddr[i] : 32'hDEAD_BEEF, 32'h200 + 32'(4 * i));
      end
      chk("no I during D", 32'((n_irv - n0) + (n_idone - nd)), 32'h0);
      wdata_pat = 0;

      // Simultaneous requests; D asks for two lines, I for one
      fix_lat = 0;
      q_done_own.delete();
      pi = n_idone; pd = n_ddone; nd = 0; k = 0;
      I_ADDR = 32'h600; D_ADDR = 32'h700; I_REQ = 1'b1; D_REQ = 1'b1;
      while (q_done_own.size() < 3 && k < 80) begin
         next(); k++;
         if (n_ddone != pd) begin nd++; pd = n_ddone; if (nd == 2) D_REQ = 1'b0; end
         if (n_idone != pi) begin pi = n_idone; I_REQ = 1'b0; end
      end
      I_REQ = 1'b0; D_REQ = 1'b0;
`ifdef MEM_ARB_RR_EN
      exp_own = '{1, 0, 1};
`else
      exp_own = '{1, 1, 0};
`endif
      for (int i = 0; i < 3; i++)
         chk("grant order", (i < q_done_own.size()) ? 32'(q_done_own[i]) : 32'hF, 32'(exp_own[i]));

      // Reset during beat 2 of a D refill
      next();
      fix_lat = 1;
      D_ADDR = 32'h300; D_REQ = 1'b1; k = 0;
      while (!(M_CS && BEAT == 2'd2) && k < 40) begin next(); k++; end
      chk("reach beat 2", 32'(M_CS && BEAT == 2'd2), 32'h1);
      nd = n_ddone;
      RST = 1'b1; D_REQ = 1'b0;
      next();
      RST = 1'b0;
      chk("post-rst M_CS", 32'(M_CS), 32'h0);
      chk("post-rst BEAT", 32'(BEAT), 32'h0);
      I_ADDR = 32'h400; I_REQ = 1'b1;
      wait_done(0, n_idone + 1, 40);
      I_REQ = 1'b0;
      chk("no D_DONE after rst", 32'(n_ddone - nd), 32'h0);

      // I drops request after first beat; memory toggles M_RDY while idle
      idle_noise = 1;
      repeat (6) next();
      n0 = n_irv; nexp = n_idone + 1; k = 0;
      I_ADDR = 32'h500; I_REQ = 1'b1;
      while (n_irv == n0 && k < 20) begin next(); k++; end
      I_REQ = 1'b0;
      wait_done(0, nexp, 40);
      chk("beats after drop", 32'(n_irv - n0), 32'd4);
      repeat (6) next();

      // Randomized traffic
      rand_lat = 1;
      pi = n_idone; pd = n_ddone;
      for (int t = 0; t < 4000; t++) begin
         next();
         RST = ($urandom_range(0, 599) == 0);
         if (I_REQ && n_idone != pi) I_REQ = 1'b0;
         else if (I_REQ && $urandom_range(0, 40) == 0) I_REQ = 1'b0;
         else if (!I_REQ && $urandom_range(0, 2) == 0) begin
            I_ADDR = $urandom() & LMASK; I_REQ = 1'b1;
         end
         if (D_REQ && n_ddone != pd) D_REQ = 1'b0;
         else if (D_REQ && $urandom_range(0, 40) == 0) D_REQ = 1'b0;
         else if (!D_REQ && $urandom_range(0, 2) == 0) begin
            D_ADDR = $urandom() & LMASK; D_WE = 1'($urandom_range(0, 1)); D_REQ = 1'b1;
         end
         pi = n_idone; pd = n_ddone;
         if ($urandom_range(0, 99) == 0) idle_noise = ~idle_noise;
      end
      RST = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0;
      repeat (20) next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter sharing the single backing-memory port between the I-cache refill path and the D-cache refill/writeback path. Each requester asks for a whole-line transfer; the block grants one requester, walks the line word by word over the memory handshake, routes read data back, and pulses a per-requester done. Sits between both caches and main memory; cache miss logic derives core stall from the outstanding requests.

## Interface
- LINE_WORDS, 4, words per cache line (power of two, ≥2)
- ADDR_W, 32, byte-address width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- I_REQ  in  1  I-cache line read request, held until I_DONE
- I_ADDR  in  ADDR_W  line-aligned read address, stable while I_REQ
- I_RVALID  out  1  I_RDATA holds a valid word this cycle
- I_RDATA  out  32  refill word
- I_DONE  out  1  one-cycle pulse, I transfer complete
- D_REQ  in  1  D-cache line request, held until D_DONE
- D_WE  in  1  1 = writeback, 0 = refill; stable while D_REQ
- D_ADDR  in  ADDR_W  line-aligned address
- D_WDATA  in  32  writeback word for index BEAT
- D_WREADY  out  1  current D_WDATA word consumed this cycle
- D_RVALID  out  1  D_RDATA valid this cycle
- D_RDATA  out  32  refill word
- D_DONE  out  1  one-cycle pulse, D transfer complete
- BEAT  out  log2(LINE_WORDS)  word index of the current beat
- M_CS  out  1  memory access request, held until M_RDY
- M_WE  out  1  memory write
- M_ADDR  out  ADDR_W  line base + BEAT*4
- M_WDATA  out  32  equals D_WDATA during D writes, else 0
- M_RDATA  in  32  read word, valid with M_RDY
- M_RDY  in  1  memory completes current beat (any latency ≥1 cycle after M_CS rises)

## Operation
- States: IDLE, XFER_I, XFER_D, DONE.
- IDLE: sample I_REQ/D_REQ; on any request latch address, D_WE and owner; BEAT←0; go XFER_I or XFER_D. Requests ignored outside IDLE.
- Arbitration (no macro): D wins over I on simultaneous requests.
- XFER_x: M_CS=1, M_ADDR={line base, BEAT, 2'b00}, M_WE=1 only for D writeback. On M_RDY: read → owner's xRVALID=1, xRDATA=M_RDATA (combinational pass-through); write → D_WREADY=1. BEAT increments; on M_RDY with BEAT==LINE_WORDS-1 go DONE.
- DONE: M_CS=0; owner's xDONE=1 for exactly this cycle; next state IDLE unconditionally (requester drops REQ at the edge ending DONE).
- Non-owner RVALID/WREADY/DONE stay 0 throughout.
- Requester dropping REQ mid-transfer: ignored, line completes.
- M_RDY while not in XFER: ignored.

## Timing
- Reset: state IDLE, BEAT 0, all outputs 0, RR pointer favours D.
- RST mid-transfer: immediate return to IDLE next edge, no DONE pulse, M_CS low next cycle.
- Request sampled at edge n → M_CS high in cycle n+1.
- Each beat: one cycle minimum (M_RDY in first cycle of M_CS) → line of LINE_WORDS beats with zero-wait memory: request-to-DONE = LINE_WORDS+2 cycles; back-to-back grants separated by one IDLE cycle.
- M_ADDR, M_WE, BEAT stable throughout a beat; change only on the edge after M_RDY.
- BEAT wraps to 0 on leaving DONE; never exceeds LINE_WORDS-1.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on simultaneous requests; the requester granted last loses the next tie; pointer updates on grant, reset favours D.
- Undefined: fixed D-over-I priority, no pointer register.

## Structure
- Package mem_arb_pkg: state encoding (IDLE/XFER_I/XFER_D/DONE), owner encoding (OWN_I, OWN_D), word-offset constant 2.
- One sub-module mem_arb_pick: combinational pick of owner from I_REQ, D_REQ and RR pointer; pointer register lives in mem_arbiter.

## Test plan
- I_REQ, I_ADDR=0x100, zero-wait memory returning 0xA0..0xA3 → M_ADDR 0x100/104/108/10C, I_RVALID ×4 with those words, I_DONE at cycle 6 after request.
- D_REQ D_WE=1 D_ADDR=0x200, 2-cycle M_RDY latency → M_WE=1, M_WDATA tracks D_WDATA per BEAT, 4 D_WREADY pulses, D_DONE once, no I outputs.
- I_REQ and D_REQ same cycle twice: without MEM_ARB_RR_EN → D,D then I; with it → D then I then D.
- RST asserted during beat 2 of D refill → next cycle IDLE, M_CS=0, BEAT=0, no D_DONE; new I_REQ served normally after.
- I_REQ dropped after beat 1 → all 4 beats still issued, I_DONE pulses; M_RDY while IDLE → no outputs change.
